pipe_hold_ctrl: RTL and testbench
=================================

Name: pipe_hold_ctrl

Overview:
- Central hold/flush scheduler for the five-stage core.
- Each cycle it drives one hold flag per pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) and the PC redirect.
- Requests come from bus wait, the multi-cycle divider, EX-stage jump/mispredict, ID load-use detection and the external interrupt line.
- It sequences multi-cycle events (divide wait, interrupt drain/entry) with a small FSM and counters.

Parameters:
- HOLD_W, 2, hold flag width. Codes: HOLD_NONE=0, HOLD_WAIT=1, HOLD_FLUSH=2.
- ADDR_W, 32, instruction address width.
- DIV_TIMEOUT, 40, max DIV_BUSY cycles before abort.
- DRAIN_CYCLES, 2, interrupt drain length in cycles (>=1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- bus_wait_i  in  1  MEM-stage bus not ready.
- div_start_i  in  1  EX issues a divide (1-cycle pulse).
- div_done_i  in  1  divider result valid.
- jump_req_i  in  1  EX-stage redirect (taken jump or mispredict).
- jump_addr_i  in  ADDR_W  redirect target.
- load_use_i  in  1  ID detects load-use hazard.
- irq_req_i  in  1  level interrupt request.
- irq_vector_i  in  ADDR_W  handler address.
- resume_pc_i  in  ADDR_W  PC of oldest not-yet-retired instruction in ID.
- pc_hold_flag_o, if_id_hold_flag_o, id_ex_hold_flag_o, ex_mem_hold_flag_o, mem_wb_hold_flag_o  out  HOLD_W  per-stage hold code.
- pc_jump_en_o  out  1  load pc_jump_addr_o into PC this cycle.
- pc_jump_addr_o  out  ADDR_W  redirect target.
- irq_ack_o  out  1  1-cycle pulse on interrupt entry.
- epc_o  out  ADDR_W  registered return address.
- div_timeout_o  out  1  1-cycle pulse on divide abort.

Behaviour:
- State register: IDLE, DIV_BUSY, IRQ_DRAIN, IRQ_JUMP. Counter cnt shared by DIV_BUSY and IRQ_DRAIN.
- Flag and jump outputs are combinational from state plus inputs. Everything else is registered.
- Default: all flags NONE, pc_jump_en_o=0, pc_jump_addr_o=0, irq_ack_o=0, div_timeout_o=0.
- Reset (any time, including mid-sequence): state=IDLE, cnt=0, epc_o=0. All outputs take default values immediately (async).
- bus_wait_i, in any state:
  - pc, if_id, id_ex, ex_mem = WAIT; mem_wb = FLUSH.
  - State and cnt frozen. No other request is acted on that cycle.
  - jump_req_i is ignored and is re-presented by the held EX stage.
- IDLE, priority below bus_wait:
  - div_start_i: -> DIV_BUSY, cnt=0. Flags pc, if_id, id_ex = WAIT; ex_mem = FLUSH.
  - else jump_req_i: pc_jump_en_o=1, pc_jump_addr_o=jump_addr_i; if_id, id_ex = FLUSH.
  - else load_use_i: pc, if_id = WAIT; id_ex = FLUSH.
  - else irq_req_i: -> IRQ_DRAIN, cnt=0, epc<=resume_pc_i. This cycle pc = WAIT; if_id, id_ex = FLUSH.
- DIV_BUSY:
  - pc, if_id, id_ex = WAIT; ex_mem = FLUSH; cnt+1 per cycle.
  - div_done_i: flags NONE that cycle; -> IDLE.
  - cnt==DIV_TIMEOUT-1 without done: div_timeout_o=1, -> IDLE, flags NONE.
  - div_done_i and timeout in the same cycle: done wins, no timeout pulse.
  - irq_req_i is not taken here; it is taken from IDLE afterwards.
- IRQ_DRAIN:
  - pc = WAIT; if_id, id_ex = FLUSH; ex_mem, mem_wb = NONE, letting EX/MEM retire.
  - cnt+1 per cycle; at cnt==DRAIN_CYCLES-1 -> IRQ_JUMP.
  - jump_req_i here: epc<=jump_addr_i. No redirect.
  - div_start_i here: ignored (that ID instruction was flushed).
- IRQ_JUMP, exactly 1 cycle:
  - pc_jump_en_o=1, pc_jump_addr_o=irq_vector_i, irq_ack_o=1; if_id, id_ex = FLUSH; -> IDLE.
  - irq_req_i deassertion after entry to IRQ_DRAIN does not cancel the sequence.
- cnt width: clog2(max(DIV_TIMEOUT, DRAIN_CYCLES))+1. No wrap: state always exits before overflow.

Test Plan:
- Load-use: load_use_i=1 for 1 cycle in IDLE -> pc/if_id=1, id_ex=2, others 0, pc_jump_en_o=0; next cycle all 0.
- Jump plus load-use: jump_req_i=1, jump_addr_i=0x0000_0100, load_use_i=1 -> pc_jump_en_o=1, addr 0x100, if_id=id_ex=2, pc=0.
- Divide: div_start_i pulse, div_done_i 5 cycles later -> 5 cycles of pc/if_id/id_ex=1, ex_mem=2; done cycle all 0; state IDLE; no timeout pulse.
- Divide timeout: div_start_i, done never asserted -> div_timeout_o pulses exactly once, 40 cycles after entry (DIV_TIMEOUT=40); flags 0 afterwards.
- Interrupt: resume_pc_i=0x200, irq_vector_i=0x8, irq_req_i=1 in IDLE, jump_req_i with 0x300 in first drain cycle -> 2 drain cycles, then one cycle pc_jump_en_o=1 addr 0x8, irq_ack_o=1; epc_o=0x300.
- Bus wait plus reset: bus_wait_i=1 in DIV_BUSY for 3 cycles -> cnt frozen, mem_wb=2, others 1. Then assert rst mid-sequence -> all flags 0, epc_o=0, IDLE, with no clock edge needed.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
// Central hold/flush scheduler for the five-stage core: per-stage hold codes,
// PC redirect, and the divide-wait and interrupt drain/entry sequences.
module pipe_hold_ctrl #(
  parameter int HOLD_W       = 2,
  parameter int ADDR_W       = 32,
  parameter int DIV_TIMEOUT  = 40,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_wait_i,
  input  logic              div_start_i,
  input  logic              div_done_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_vector_i,
  input  logic [ADDR_W-1:0] resume_pc_i,
  output logic [HOLD_W-1:0] pc_hold_flag_o,
  output logic [HOLD_W-1:0] if_id_hold_flag_o,
  output logic [HOLD_W-1:0] id_ex_hold_flag_o,
  output logic [HOLD_W-1:0] ex_mem_hold_flag_o,
  output logic [HOLD_W-1:0] mem_wb_hold_flag_o,
  output logic              pc_jump_en_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic              irq_ack_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              div_timeout_o
);

  localparam logic [HOLD_W-1:0] HOLD_NONE  = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_WAIT  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_FLUSH = HOLD_W'(2);

  localparam int CNT_MAX = (DIV_TIMEOUT > DRAIN_CYCLES) ? DIV_TIMEOUT : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_BUSY,
    ST_IRQ_DRAIN,
    ST_IRQ_JUMP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d            = state_q;
    cnt_d              = cnt_q;
    epc_d              = epc_q;
    pc_hold_flag_o     = HOLD_NONE;
    if_id_hold_flag_o  = HOLD_NONE;
    id_ex_hold_flag_o  = HOLD_NONE;
    ex_mem_hold_flag_o = HOLD_NONE;
    mem_wb_hold_flag_o = HOLD_NONE;
    pc_jump_en_o       = 1'b0;
    pc_jump_addr_o     = '0;
    irq_ack_o          = 1'b0;
    div_timeout_o      = 1'b0;

    // Outputs sit at their defaults for as long as reset is held.
    if (!rst) begin
      if (bus_wait_i) begin
        // Bus stall freezes everything; the held EX stage re-presents any jump.
        pc_hold_flag_o     = HOLD_WAIT;
        if_id_hold_flag_o  = HOLD_WAIT;
        id_ex_hold_flag_o  = HOLD_WAIT;
        ex_mem_hold_flag_o = HOLD_WAIT;
        mem_wb_hold_flag_o = HOLD_FLUSH;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (div_start_i) begin
              state_d            = ST_DIV_BUSY;
              cnt_d              = CNT_ZERO;
              pc_hold_flag_o     = HOLD_WAIT;
              if_id_hold_flag_o  = HOLD_WAIT;
              id_ex_hold_flag_o  = HOLD_WAIT;
              ex_mem_hold_flag_o = HOLD_FLUSH;
            end else if (jump_req_i) begin
              pc_jump_en_o      = 1'b1;
              pc_jump_addr_o    = jump_addr_i;
              if_id_hold_flag_o = HOLD_FLUSH;
              id_ex_hold_flag_o = HOLD_FLUSH;
            end else if (load_use_i) begin
              pc_hold_flag_o    = HOLD_WAIT;
              if_id_hold_flag_o = HOLD_WAIT;
              id_ex_hold_flag_o = HOLD_FLUSH;
            end else if (irq_req_i) begin
              state_d           = ST_IRQ_DRAIN;
              cnt_d             = CNT_ZERO;
              epc_d             = resume_pc_i;
              pc_hold_flag_o    = HOLD_WAIT;
              if_id_hold_flag_o = HOLD_FLUSH;
              id_ex_hold_flag_o = HOLD_FLUSH;
            end
          end

          ST_DIV_BUSY: begin
            if (div_done_i) begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end else if (cnt_q == DIV_LAST) begin
              state_d       = ST_IDLE;
              cnt_d         = CNT_ZERO;
              div_timeout_o = 1'b1;
            end else begin
              cnt_d              = cnt_q + CNT_ONE;
              pc_hold_flag_o     = HOLD_WAIT;
              if_id_hold_flag_o  = HOLD_WAIT;
              id_ex_hold_flag_o  = HOLD_WAIT;
              ex_mem_hold_flag_o = HOLD_FLUSH;
            end
          end

          ST_IRQ_DRAIN: begin
            // EX/MEM retire; a redirect from EX moves the return address instead.
            pc_hold_flag_o    = HOLD_WAIT;
            if_id_hold_flag_o = HOLD_FLUSH;
            id_ex_hold_flag_o = HOLD_FLUSH;
            if (jump_req_i) epc_d = jump_addr_i;
            if (cnt_q == DRAIN_LAST) begin
              state_d = ST_IRQ_JUMP;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end

          ST_IRQ_JUMP: begin
            pc_jump_en_o      = 1'b1;
            pc_jump_addr_o    = irq_vector_i;
            irq_ack_o         = 1'b1;
            if_id_hold_flag_o = HOLD_FLUSH;
            id_ex_hold_flag_o = HOLD_FLUSH;
            state_d           = ST_IDLE;
          end

          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  assign epc_o = epc_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl with hand-computed expectations.
module tb_pipe_hold_ctrl;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] W = 2'd1;
  localparam logic [1:0] F = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_wait, div_start, div_done, jump_req, load_use, irq_req;
  logic [31:0] jump_addr, irq_vector, resume_pc;
  logic [1:0]  pc_f, if_id_f, id_ex_f, ex_mem_f, mem_wb_f;
  logic        jump_en, irq_ack, div_timeout;
  logic [31:0] jump_addr_o, epc;
  logic [9:0]  flags;

  int checks = 0;
  int errors = 0;

  pipe_hold_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .bus_wait_i         (bus_wait),
    .div_start_i        (div_start),
    .div_done_i         (div_done),
    .jump_req_i         (jump_req),
    .jump_addr_i        (jump_addr),
    .load_use_i         (load_use),
    .irq_req_i          (irq_req),
    .irq_vector_i       (irq_vector),
    .resume_pc_i        (resume_pc),
    .pc_hold_flag_o     (pc_f),
    .if_id_hold_flag_o  (if_id_f),
    .id_ex_hold_flag_o  (id_ex_f),
    .ex_mem_hold_flag_o (ex_mem_f),
    .mem_wb_hold_flag_o (mem_wb_f),
    .pc_jump_en_o       (jump_en),
    .pc_jump_addr_o     (jump_addr_o),
    .irq_ack_o          (irq_ack),
    .epc_o              (epc),
    .div_timeout_o      (div_timeout)
  );

  always #5 clk = ~clk;

  assign flags = {pc_f, if_id_f, id_ex_f, ex_mem_f, mem_wb_f};

  function automatic logic [9:0] fl(logic [1:0] p, logic [1:0] i, logic [1:0] d,
                                    logic [1:0] e, logic [1:0] m);
    return {p, i, d, e, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_wait  = 1'b0;
    div_start = 1'b0;
    div_done  = 1'b0;
    jump_req  = 1'b0;
    load_use  = 1'b0;
    irq_req   = 1'b0;
    jump_addr = 32'h0;
  endtask

  initial begin
    int pulses;
    int pulse_k;

    rst        = 1'b1;
    irq_vector = 32'h0;
    resume_pc  = 32'h0;
    clear_inputs();
    #12;
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_jump_en", 32'(jump_en), 32'h0);
    check("reset_epc", epc, 32'h0);
    tick();
    rst = 1'b0;

    // Load-use stall for one cycle.
    tick();
    load_use = 1'b1;
    #1;
    check("lu_flags", 32'(flags), 32'(fl(W, W, F, N, N)));
    check("lu_jump_en", 32'(jump_en), 32'h0);
    check("lu_jump_addr", jump_addr_o, 32'h0);
    tick();
    load_use = 1'b0;
    #1;
    check("lu_after_flags", 32'(flags), 32'h0);

    // Jump outranks load-use.
    tick();
    jump_req  = 1'b1;
    jump_addr = 32'h0000_0100;
    load_use  = 1'b1;
    #1;
    check("jmp_flags", 32'(flags), 32'(fl(N, F, F, N, N)));
    check("jmp_en", 32'(jump_en), 32'h1);
    check("jmp_addr", jump_addr_o, 32'h100);
    tick();
    clear_inputs();

    // Divide completing 5 cycles after start.
    tick();
    div_start = 1'b1;
    #1;
    check("div_start_flags", 32'(flags), 32'(fl(W, W, W, F, N)));
    for (int k = 1; k <= 4; k++) begin
      tick();
      div_start = 1'b0;
      #1;
      check($sformatf("div_busy_flags_%0d", k), 32'(flags), 32'(fl(W, W, W, F, N)));
    end
    tick();
    div_done = 1'b1;
    #1;
    check("div_done_flags", 32'(flags), 32'h0);
    check("div_done_no_timeout", 32'(div_timeout), 32'h0);
    tick();
    div_done = 1'b0;
    #1;
    check("div_idle_flags", 32'(flags), 32'h0);

    // Divide never completing: single timeout pulse 40 cycles after entry.
    tick();
    div_start = 1'b1;
    #1;
    pulses  = 0;
    pulse_k = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      div_start = 1'b0;
      #1;
      if (div_timeout) begin
        pulses++;
        pulse_k = k;
      end
      if (k == 39) check("to_flags_39", 32'(flags), 32'(fl(W, W, W, F, N)));
      if (k == 40) check("to_flags_40", 32'(flags), 32'h0);
      if (k == 41) check("to_flags_41", 32'(flags), 32'h0);
    end
    check("to_pulse_count", 32'(pulses), 32'd1);
    check("to_pulse_cycle", 32'(pulse_k), 32'd40);

    // Interrupt with a redirect arriving during the drain.
    tick();
    resume_pc  = 32'h200;
    irq_vector = 32'h8;
    irq_req    = 1'b1;
    #1;
    check("irq_entry_flags", 32'(flags), 32'(fl(W, F, F, N, N)));
    check("irq_entry_jump_en", 32'(jump_en), 32'h0);
    tick();
    irq_req   = 1'b0;
    jump_req  = 1'b1;
    jump_addr = 32'h300;
    #1;
    check("drain0_flags", 32'(flags), 32'(fl(W, F, F, N, N)));
    check("drain0_no_redirect", 32'(jump_en), 32'h0);
    check("drain0_epc", epc, 32'h200);
    tick();
    jump_req  = 1'b0;
    jump_addr = 32'h0;
    #1;
    check("drain1_flags", 32'(flags), 32'(fl(W, F, F, N, N)));
    check("drain1_ack", 32'(irq_ack), 32'h0);
    tick();
    check("irqj_flags", 32'(flags), 32'(fl(N, F, F, N, N)));
    check("irqj_en", 32'(jump_en), 32'h1);
    check("irqj_addr", jump_addr_o, 32'h8);
    check("irqj_ack", 32'(irq_ack), 32'h1);
    check("irqj_epc", epc, 32'h300);
    tick();
    check("irq_done_ack", 32'(irq_ack), 32'h0);
    check("irq_done_flags", 32'(flags), 32'h0);

    // Bus wait inside DIV_BUSY freezes cnt and ignores div_done.
    tick();
    div_start = 1'b1;
    pulses  = 0;
    pulse_k = 0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      div_start = 1'b0;
      bus_wait  = (k >= 3 && k <= 5);
      div_done  = (k == 4);
      #1;
      if (div_timeout) begin
        pulses++;
        pulse_k = k;
      end
      if (k == 4) check("bw_flags", 32'(flags), 32'(fl(W, W, W, W, F)));
    end
    check("bw_pulse_count", 32'(pulses), 32'd1);
    check("bw_pulse_cycle", 32'(pulse_k), 32'd43);
    bus_wait = 1'b0;
    div_done = 1'b0;

    // Asynchronous reset in the middle of a stalled divide.
    tick();
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    bus_wait  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bw_busy_flags_%0d", k), 32'(flags), 32'(fl(W, W, W, W, F)));
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_flags", 32'(flags), 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_jump_en", 32'(jump_en), 32'h0);
    tick();
    bus_wait = 1'b0;
    rst      = 1'b0;
    tick();
    check("arst_idle_flags", 32'(flags), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
